// File: rtl/step_counter_pkg.sv
// step_counter_pkg: shared types and constants for the step_counter slice.
//   step_state_t   : controller states (IDLE, RUN, DONE)
//   STEP_WIDTH_DEF : default count width
package step_counter_pkg;

  localparam int unsigned STEP_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } step_state_t;

endpackage

// File: rtl/step_counter_incrementer.sv
// incrementer: combinational +1 datapath, modulo 2^WIDTH, no carry out.
//   value      : input  WIDTH  operand
//   next_value : output WIDTH  value + 1
module incrementer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] next_value
);

  assign next_value = value + WIDTH'(1);

endmodule

// File: rtl/step_counter.sv
// step_counter: registered stepping counter around the incrementer.
// A start pulse in IDLE loads a first value and a limit. Each count is
// presented on a valid/ready stream and advances only on an accepted
// transfer. Accepting the limit value leads to a one-cycle done pulse.
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   start     : run request, sampled only in IDLE
//   load_val  : first count, sampled with start
//   limit     : last count, sampled with start
//   count_out : current count (registered)
//   out_valid : count_out presented (high in RUN)
//   out_ready : consumer accepts when out_valid is high
//   busy      : high in RUN
//   done      : one-cycle pulse after the limit value is accepted
//   wrap      : one-cycle pulse when the count rolls from all-ones to zero
// Build option: define STEP_COUNTER_SAT_EN to saturate at all-ones
// (ends the run instead of wrapping; wrap tied low).
module step_counter
  import step_counter_pkg::*;
#(
  parameter int unsigned WIDTH = STEP_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  step_state_t      state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] next_count;
  logic             xfer;
  logic             all_ones;

  incrementer #(.WIDTH(WIDTH)) u_incrementer (
    .value      (count_q),
    .next_value (next_count)
  );

  assign xfer     = (state_q == ST_RUN) && out_ready;
  assign all_ones = &count_q;

`ifndef STEP_COUNTER_SAT_EN
  logic wrap_q, wrap_d;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
`ifndef STEP_COUNTER_SAT_EN
    wrap_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d = load_val;
          limit_d = limit;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          if (count_q == limit_q) begin
            state_d = ST_DONE;
          end
`ifdef STEP_COUNTER_SAT_EN
          else if (all_ones) begin
            state_d = ST_DONE;
          end
`endif
          else begin
            count_d = next_count;
`ifndef STEP_COUNTER_SAT_EN
            // Registered so the pulse lines up with the cycle showing 0.
            wrap_d  = all_ones;
`endif
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
    end
  end

`ifdef STEP_COUNTER_SAT_EN
  assign wrap = 1'b0;
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;
`endif

  assign count_out = count_q;
  assign out_valid = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);

endmodule
